mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, maximum cycles spent in RD_WAIT before an access is abandoned.
REQ-002 SHALL provide port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port BUS_IN  input  16  processor bus value, source for MAR/MDR loads.
REQ-005 SHALL provide port LD_MAR  input  1  load MAR from BUS_IN.
REQ-006 SHALL provide port LD_MDR  input  1  load MDR from BUS_IN.
REQ-007 SHALL provide port MIO_EN  input  1  memory access request, level, held by requester until R.
REQ-008 SHALL provide port R_W  input  1  access direction: 1 write, 0 read; sampled with MIO_EN.
REQ-009 SHALL provide ports MAR_OUT, MDR_OUT  output  16  current MAR and MDR contents.
REQ-010 SHALL provide port R  output  1  access complete (ready).
REQ-011 SHALL provide port ERR  output  1  last read timed out.
REQ-012 SHALL provide ports RAM_ADDR, RAM_DATA  output  16  RAM address (MAR) and write data (MDR).
REQ-013 SHALL provide ports RAM_CS, RAM_WE  output  1  RAM chip select and write enable.
REQ-014 SHALL provide ports RAM_OUT  input  16 and RAM_READY  input  1  RAM read data and ready.
REQ-015 SHALL provide ports KBDR_IN  input  16 and KB_STROBE  input  1  keyboard character and its one-cycle valid strobe.
REQ-016 SHALL provide ports DDR_OUT  output  16 and DDR_VALID  output  1  display character and its one-cycle valid pulse.

Function
REQ-017 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE; RAM_CS/RAM_WE/R are decoded from state only.
REQ-018 SHALL, in IDLE with MIO_EN=0, load MAR on LD_MAR and MDR on LD_MDR; in all other cases LD_MAR/LD_MDR are ignored.
REQ-019 SHALL, in IDLE with MIO_EN=1, use the pre-edge MAR/MDR, clear ERR, and branch on MAR: MAR<0xFE00 is RAM, MAR>=0xFE00 is I/O.
REQ-020 SHALL, for a RAM read, go IDLE->RD_ISSUE (RAM_CS=1, RAM_WE=0, one cycle)->RD_WAIT (RAM_CS=0).
REQ-021 SHALL, in RD_WAIT with RAM_READY=1, load MDR<=RAM_OUT and go to DONE; minimum read latency is MIO_EN to R in 3 cycles.
REQ-022 SHALL count RD_WAIT cycles; on the TIMEOUT-th cycle without RAM_READY, set MDR=0x0000 and ERR=1 and go to DONE.
REQ-023 SHALL, for a RAM write, go IDLE->WR_ISSUE (RAM_CS=1, RAM_WE=1, one cycle)->DONE.
REQ-024 SHALL complete I/O accesses IDLE->DONE in one edge, with no RAM_CS.
REQ-025 SHALL return these I/O read values: 0xFE00 KBSR = {kb_ready,15'b0}; 0xFE02 KBDR, which also clears kb_ready; 0xFE04 DSR = 0x8000; any other I/O address = 0x0000.
REQ-026 SHALL, on an I/O write to 0xFE06, set DDR_OUT<=MDR with DDR_VALID=1 for exactly one cycle; writes to other I/O addresses are dropped without error.
REQ-027 SHALL, on KB_STROBE with kb_ready=0, load KBDR<=KBDR_IN and set kb_ready=1; a strobe with kb_ready=1 is dropped.
REQ-028 SHALL, when a KBDR read clear and KB_STROBE occur on the same edge, let the strobe win: new character loaded, kb_ready stays 1.
REQ-029 SHALL hold R=1 throughout DONE and leave DONE for IDLE only when MIO_EN=0, so one request never starts two accesses.
REQ-030 SHALL hold ERR until the next access leaves IDLE; RAM_ADDR=MAR and RAM_DATA=MDR combinationally at all times.

Reset
REQ-031 SHALL, while RESET_N=0, force state IDLE; MAR, MDR, KBDR, DDR_OUT and the wait counter to 0x0000/0; kb_ready, R, ERR, DDR_VALID, RAM_CS, RAM_WE to 0.
REQ-032 SHALL, on reset asserted mid-access, abort immediately with no further RAM_CS; after release, the first access needs a fresh MIO_EN.

Verification
REQ-033 SHALL cover RAM read: MAR=0x0001, MIO_EN=1, R_W=0, RAM_READY returned after 2 wait cycles with RAM_OUT=0x1261 -> one RD_ISSUE CS pulse, MDR=0x1261, R=1 until MIO_EN drops, ERR=0.
REQ-034 SHALL cover RAM write: MAR=0x3000, MDR=0xABCD, MIO_EN=1, R_W=1 -> exactly one cycle with RAM_CS=RAM_WE=1, ADDR=0x3000, DATA=0xABCD, then R=1.
REQ-035 SHALL cover timeout: TIMEOUT=15, RAM_READY held 0 -> exactly 15 RD_WAIT cycles, then MDR=0x0000, ERR=1, R=1; the next access clears ERR.
REQ-036 SHALL cover keyboard: KB_STROBE with KBDR_IN=0x0041 -> KBSR read gives 0x8000, KBDR read gives 0x0041, then KBSR read gives 0x0000; a second strobe while kb_ready=1 is dropped.
REQ-037 SHALL cover display: MDR=0x0048 written to 0xFE06 -> DDR_OUT=0x0048, DDR_VALID high for exactly one cycle, DSR read gives 0x8000.
REQ-038 SHALL cover reset in RD_WAIT and held MIO_EN: RESET_N=0 in RD_WAIT -> all outputs reset asynchronously; MIO_EN held high through DONE -> no second RAM_CS pulse.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory/I-O access controller: MAR/MDR register pair, RAM read/write sequencing with
// read timeout, and memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
module mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] BUS_IN,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic [15:0] MAR_OUT,
  output logic [15:0] MDR_OUT,
  output logic        R,
  output logic        ERR,
  output logic [15:0] RAM_ADDR,
  output logic [15:0] RAM_DATA,
  output logic        RAM_CS,
  output logic        RAM_WE,
  input  logic [15:0] RAM_OUT,
  input  logic        RAM_READY,
  input  logic [15:0] KBDR_IN,
  input  logic        KB_STROBE,
  output logic [15:0] DDR_OUT,
  output logic        DDR_VALID
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [15:0] mar_reg, mar_next;
  logic [15:0] mdr_reg, mdr_next;
  logic [15:0] kbdr_reg, kbdr_next;
  logic [15:0] ddr_reg, ddr_next;
  logic        kb_ready_reg, kb_ready_next;
  logic        err_reg, err_next;
  logic        ddr_valid_reg, ddr_valid_next;
  logic        armed_reg, armed_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  logic        start;
  logic        is_io;
  logic        kbdr_clear;
  logic        ddr_write;
  logic        timeout_hit;
  logic [15:0] io_rd_data;

  // An access is only accepted once MIO_EN has been seen low since reset,
  // so a request left asserted across reset never starts a second access.
  assign start       = (state_reg == IDLE) && MIO_EN && armed_reg;
  assign is_io       = (mar_reg >= IO_BASE);
  assign kbdr_clear  = start && is_io && !R_W && (mar_reg == ADDR_KBDR);
  assign ddr_write   = start && is_io && R_W && (mar_reg == ADDR_DDR);
  assign timeout_hit = (state_reg == RD_WAIT) && !RAM_READY &&
                       (wait_cnt_reg == CW'(TIMEOUT - 1));

  always_comb begin
    io_rd_data = 16'h0000;
    case (mar_reg)
      ADDR_KBSR: io_rd_data = {kb_ready_reg, 15'b0};
      ADDR_KBDR: io_rd_data = kbdr_reg;
      ADDR_DSR:  io_rd_data = 16'h8000;
      default:   io_rd_data = 16'h0000;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_io)     state_next = DONE;
          else if (R_W)  state_next = WR_ISSUE;
          else           state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (RAM_READY || timeout_hit) state_next = DONE;
      end
      WR_ISSUE: state_next = DONE;
      DONE: begin
        if (!MIO_EN) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode, from state only
  always_comb begin
    RAM_CS = 1'b0;
    RAM_WE = 1'b0;
    R      = 1'b0;
    case (state_reg)
      RD_ISSUE: RAM_CS = 1'b1;
      WR_ISSUE: begin
        RAM_CS = 1'b1;
        RAM_WE = 1'b1;
      end
      DONE:     R = 1'b1;
      default: begin
        RAM_CS = 1'b0;
        RAM_WE = 1'b0;
        R      = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    mar_next       = mar_reg;
    mdr_next       = mdr_reg;
    kbdr_next      = kbdr_reg;
    ddr_next       = ddr_reg;
    kb_ready_next  = kb_ready_reg;
    err_next       = err_reg;
    ddr_valid_next = 1'b0;
    armed_next     = armed_reg | !MIO_EN;
    wait_cnt_next  = '0;

    if ((state_reg == IDLE) && !MIO_EN) begin
      if (LD_MAR) mar_next = BUS_IN;
      if (LD_MDR) mdr_next = BUS_IN;
    end

    if (start) begin
      err_next = 1'b0;
      if (is_io && !R_W) mdr_next = io_rd_data;
      if (ddr_write) begin
        ddr_next       = mdr_reg;
        ddr_valid_next = 1'b1;
      end
    end

    if (state_reg == RD_WAIT) begin
      if (RAM_READY) begin
        mdr_next = RAM_OUT;
      end else if (timeout_hit) begin
        mdr_next = 16'h0000;
        err_next = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + CW'(1);
      end
    end

    // A strobe arriving on the same edge as a KBDR read replaces the character.
    if (KB_STROBE && (!kb_ready_reg || kbdr_clear)) begin
      kbdr_next     = KBDR_IN;
      kb_ready_next = 1'b1;
    end else if (kbdr_clear) begin
      kb_ready_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mar_reg       <= 16'h0000;
      mdr_reg       <= 16'h0000;
      kbdr_reg      <= 16'h0000;
      ddr_reg       <= 16'h0000;
      kb_ready_reg  <= 1'b0;
      err_reg       <= 1'b0;
      ddr_valid_reg <= 1'b0;
      armed_reg     <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      mar_reg       <= mar_next;
      mdr_reg       <= mdr_next;
      kbdr_reg      <= kbdr_next;
      ddr_reg       <= ddr_next;
      kb_ready_reg  <= kb_ready_next;
      err_reg       <= err_next;
      ddr_valid_reg <= ddr_valid_next;
      armed_reg     <= armed_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  assign MAR_OUT   = mar_reg;
  assign MDR_OUT   = mdr_reg;
  assign ERR       = err_reg;
  assign RAM_ADDR  = mar_reg;
  assign RAM_DATA  = mdr_reg;
  assign DDR_OUT   = ddr_reg;
  assign DDR_VALID = ddr_valid_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected MDR/ERR per access, a
// negedge monitor pops and compares whenever R rises; a RAM model answers reads.
module tb_mem_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] BUS_IN;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic        R;
  logic        ERR;
  logic [15:0] RAM_ADDR;
  logic [15:0] RAM_DATA;
  logic        RAM_CS;
  logic        RAM_WE;
  logic [15:0] RAM_OUT = 16'h0000;
  logic        RAM_READY = 1'b0;
  logic [15:0] KBDR_IN;
  logic        KB_STROBE;
  logic [15:0] DDR_OUT;
  logic        DDR_VALID;

  mem_ctrl #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUS_IN(BUS_IN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT), .R(R), .ERR(ERR),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_CS(RAM_CS), .RAM_WE(RAM_WE),
    .RAM_OUT(RAM_OUT), .RAM_READY(RAM_READY), .KBDR_IN(KBDR_IN), .KB_STROBE(KB_STROBE),
    .DDR_OUT(DDR_OUT), .DDR_VALID(DDR_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  logic [15:0] ddr_q[$];

  int cs_cnt = 0;
  int we_cnt = 0;
  int ddr_cnt = 0;
  logic [15:0] wr_addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  logic r_prev = 1'b0;

  int ram_delay = 0;
  logic [15:0] ram_data = 16'h0000;
  logic in_rd = 1'b0;
  int wcnt = 0;
  int rd_wait_cycles = 0;
  int last_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=0x%0h t=%0t", name, act, $time);
    end
  endtask

  // Response monitor and bus activity counters
  always @(negedge CLK) begin
    if (R && !r_prev) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'(R), 32'(0));
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("resp_mdr", 32'(MDR_OUT), 32'(e[15:0]));
        chk("resp_err", 32'(ERR), 32'(e[16]));
      end
    end
    r_prev <= R;
    if (RAM_CS) cs_cnt <= cs_cnt + 1;
    if (RAM_CS && RAM_WE) begin
      we_cnt  <= we_cnt + 1;
      wr_addr <= RAM_ADDR;
      wr_data <= RAM_DATA;
    end
    if (DDR_VALID) begin
      ddr_cnt <= ddr_cnt + 1;
      if (ddr_q.size() == 0) begin
        chk("ddr_unexpected", 32'(DDR_VALID), 32'(0));
      end else begin
        logic [15:0] d;
        d = ddr_q.pop_front();
        chk("ddr_out", 32'(DDR_OUT), 32'(d));
      end
    end
  end

  // RAM model: ready after ram_delay RD_WAIT cycles without it (negative = never)
  always @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_rd     <= 1'b0;
      RAM_READY <= 1'b0;
      wcnt      <= 0;
    end else if (RAM_CS && !RAM_WE) begin
      in_rd     <= 1'b1;
      wcnt      <= 0;
      RAM_READY <= 1'b0;
    end else if (in_rd) begin
      if (R) begin
        in_rd          <= 1'b0;
        RAM_READY      <= 1'b0;
        rd_wait_cycles <= wcnt;
      end else begin
        wcnt <= wcnt + 1;
        if (ram_delay >= 0 && wcnt + 1 > ram_delay) begin
          RAM_READY <= 1'b1;
          RAM_OUT   <= ram_data;
        end
      end
    end
  end

  task automatic load_mar(input logic [15:0] v);
    BUS_IN = v; LD_MAR = 1'b1;
    @(negedge CLK);
    LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    BUS_IN = v; LD_MDR = 1'b1;
    @(negedge CLK);
    LD_MDR = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] c);
    KBDR_IN = c; KB_STROBE = 1'b1;
    @(negedge CLK);
    KB_STROBE = 1'b0;
  endtask

  task automatic do_access(input logic rw, input logic [15:0] exp_mdr,
                           input logic exp_err, input int hold);
    int n;
    n = 0;
    exp_q.push_back({exp_err, exp_mdr});
    R_W = rw; MIO_EN = 1'b1;
    while (!R && n < 40) begin @(negedge CLK); n++; end
    last_lat = n;
    chk("r_seen", 32'(R), 32'(1));
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("r_held", 32'(R), 32'(1));
    end
    MIO_EN = 1'b0;
    n = 0;
    while (R && n < 5) begin @(negedge CLK); n++; end
    chk("r_drop", 32'(R), 32'(0));
  endtask

  initial begin
    int cs0, we0, dd0;
    RESET_N = 1'b0; BUS_IN = 16'h0000; LD_MAR = 1'b0; LD_MDR = 1'b0;
    MIO_EN = 1'b0; R_W = 1'b0; KBDR_IN = 16'h0000; KB_STROBE = 1'b0;
    #12;
    chk("rst_mar", 32'(MAR_OUT), 32'h0);
    chk("rst_mdr", 32'(MDR_OUT), 32'h0);
    chk("rst_r", 32'(R), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    chk("rst_cs", 32'({RAM_CS, RAM_WE}), 32'h0);
    chk("rst_ddr", 32'({DDR_VALID, DDR_OUT}), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // RAM read, two unready wait cycles, MIO_EN held past R
    load_mar(16'h0001);
    ram_delay = 2; ram_data = 16'h1261; cs0 = cs_cnt;
    do_access(1'b0, 16'h1261, 1'b0, 4);
    chk("rd_cs_pulses", 32'(cs_cnt - cs0), 32'd1);
    chk("rd_wait_cycles", 32'(rd_wait_cycles), 32'd3);

    // RAM write
    load_mar(16'h3000);
    load_mdr(16'hABCD);
    cs0 = cs_cnt; we0 = we_cnt;
    do_access(1'b1, 16'hABCD, 1'b0, 0);
    chk("wr_cs_pulses", 32'(cs_cnt - cs0), 32'd1);
    chk("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("wr_addr", 32'(wr_addr), 32'h3000);
    chk("wr_data", 32'(wr_data), 32'hABCD);

    // Minimum read latency
    load_mar(16'h0010);
    ram_delay = 0; ram_data = 16'h00FF;
    do_access(1'b0, 16'h00FF, 1'b0, 0);
    chk("rd_latency", 32'(last_lat), 32'd3);

    // Timeout, ERR held in IDLE, cleared by next access
    load_mar(16'h0020);
    load_mdr(16'h5A5A);
    ram_delay = -1;
    do_access(1'b0, 16'h0000, 1'b1, 0);
    chk("to_wait_cycles", 32'(rd_wait_cycles), 32'd15);
    @(negedge CLK);
    chk("to_err_held", 32'(ERR), 32'd1);
    load_mar(16'h0021);
    ram_delay = 0; ram_data = 16'h7777;
    do_access(1'b0, 16'h7777, 1'b0, 0);

    // Keyboard
    strobe(16'h0041);
    load_mar(16'hFE00);
    do_access(1'b0, 16'h8000, 1'b0, 0);
    chk("io_latency", 32'(last_lat), 32'd1);
    load_mar(16'hFE02);
    do_access(1'b0, 16'h0041, 1'b0, 0);
    load_mar(16'hFE00);
    do_access(1'b0, 16'h0000, 1'b0, 0);
    strobe(16'h0041);
    strobe(16'h0042);
    load_mar(16'hFE02);
    do_access(1'b0, 16'h0041, 1'b0, 0);
    strobe(16'h0051);
    load_mar(16'hFE02);
    KBDR_IN = 16'h0052; KB_STROBE = 1'b1;
    fork
      do_access(1'b0, 16'h0051, 1'b0, 0);
      begin @(negedge CLK); KB_STROBE = 1'b0; end
    join
    load_mar(16'hFE00);
    do_access(1'b0, 16'h8000, 1'b0, 0);
    load_mar(16'hFE02);
    do_access(1'b0, 16'h0052, 1'b0, 0);

    // Display
    load_mar(16'hFE06);
    load_mdr(16'h0048);
    ddr_q.push_back(16'h0048);
    dd0 = ddr_cnt; cs0 = cs_cnt;
    do_access(1'b1, 16'h0048, 1'b0, 0);
    repeat (2) @(negedge CLK);
    chk("ddr_pulses", 32'(ddr_cnt - dd0), 32'd1);
    chk("ddr_hold", 32'(DDR_OUT), 32'h0048);
    chk("io_no_cs", 32'(cs_cnt - cs0), 32'd0);
    load_mar(16'hFE04);
    do_access(1'b0, 16'h8000, 1'b0, 0);
    load_mar(16'hFE08);
    dd0 = ddr_cnt;
    do_access(1'b1, 16'h8000, 1'b0, 0);
    repeat (2) @(negedge CLK);
    chk("io_wr_drop", 32'(ddr_cnt - dd0), 32'd0);

    // Reset during RD_WAIT with MIO_EN held across it
    load_mar(16'h0002);
    ram_delay = -1;
    R_W = 1'b0; MIO_EN = 1'b1;
    repeat (4) @(negedge CLK);
    chk("pre_rst_wait", 32'({R, RAM_CS}), 32'h0);
    #3 RESET_N = 1'b0;
    #1;
    chk("arst_mar", 32'(MAR_OUT), 32'h0);
    chk("arst_mdr", 32'(MDR_OUT), 32'h0);
    chk("arst_outs", 32'({R, ERR, RAM_CS, RAM_WE, DDR_VALID}), 32'h0);
    chk("arst_ddr", 32'(DDR_OUT), 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    cs0 = cs_cnt;
    repeat (5) @(negedge CLK);
    chk("held_mio_no_cs", 32'(cs_cnt - cs0), 32'd0);
    chk("held_mio_no_r", 32'(R), 32'd0);
    MIO_EN = 1'b0;
    @(negedge CLK);
    ram_delay = 1; ram_data = 16'h5555;
    do_access(1'b0, 16'h5555, 1'b0, 0);
    chk("post_rst_cs", 32'(cs_cnt - cs0), 32'd1);

    repeat (2) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size() + ddr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
